// File: rtl/nv_async_fifo_pkg.sv
// nv_async_fifo_pkg: shared constants and Gray-code helper for the async FIFO controllers
package nv_async_fifo_pkg;
    localparam int FIFO_DEPTH_LOG2 = 4;
    localparam int FIFO_PTR_W      = FIFO_DEPTH_LOG2 + 1;
    localparam int SKID_DEPTH      = 2;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction
endpackage

// File: rtl/nv_async_fifo_gray_sync.sv
// nv_async_fifo_gray_sync: multi-flop synchronizer for a Gray-coded pointer bus
module nv_async_fifo_gray_sync
    import nv_async_fifo_pkg::*;
#(
    parameter int W      = FIFO_PTR_W,
    parameter int STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [STAGES-1:0][W-1:0] sync_q;

    // plain shift chain, nothing combinational between stages
    always_ff @(posedge clk_i)
        if (!rstn_i) sync_q <= '0;
        else         sync_q <= {sync_q[STAGES-2:0], d_i};

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/nv_async_fifo_rd_ctrl.sv
// nv_async_fifo_rd_ctrl: read-domain controller with empty detect, 2-entry output skid and read clock-gate enable
module nv_async_fifo_rd_ctrl
    import nv_async_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2  = FIFO_DEPTH_LOG2,
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rstn,
    input  logic [DEPTH_LOG2:0]   wr_ptr_gray,
    input  logic [WIDTH-1:0]      ram_rd_data,
    output logic                  ram_re,
    output logic [DEPTH_LOG2-1:0] ram_ra,
    output logic                  rd_pvld,
    input  logic                  rd_prdy,
    output logic [WIDTH-1:0]      rd_pd,
    output logic [DEPTH_LOG2:0]   rd_ptr_gray,
    input  logic                  one_hot_enable,
    input  logic                  tp,
    output logic                  rd_clk_en
);
    localparam int PTR_W = DEPTH_LOG2 + 1;

    logic [PTR_W-1:0] wr_gray_s, rd_ptr_q, rd_ptr_d, rd_ptr_gray_q;
    logic             pend_q, empty, pop;
    logic [1:0]       cnt_q, cnt_d, slot;
    logic [WIDTH-1:0] skid0_q, skid1_q, skid0_d, skid1_d;

    nv_async_fifo_gray_sync #(.W(PTR_W), .STAGES(SYNC_STAGES)) u_wr_sync (
        .clk_i  (nvdla_core_clk),
        .rstn_i (nvdla_core_rstn),
        .d_i    (wr_ptr_gray),
        .q_o    (wr_gray_s)
    );

    // issue decision, skid write slot and clock-gate enable
    always_comb begin
        empty     = rd_ptr_gray_q == wr_gray_s;
        pop       = rd_pvld & rd_prdy;
        cnt_d     = cnt_q + {1'b0, pend_q} - {1'b0, pop};
        ram_re    = nvdla_core_rstn & !empty & (cnt_d < 2'(SKID_DEPTH));
        rd_ptr_d  = rd_ptr_q + PTR_W'(ram_re);
        slot      = cnt_q - {1'b0, pop};
        skid0_d   = (pend_q && slot == 2'd0) ? ram_rd_data : pop ? skid1_q : skid0_q;
        skid1_d   = (pend_q && slot == 2'd1) ? ram_rd_data : skid1_q;
        rd_clk_en = (!one_hot_enable | !tp) & (!empty | pend_q | (cnt_q != 2'd0) | !nvdla_core_rstn);
    end

    // read pointer, in-flight flag and skid storage; reset discards in-flight data
    always_ff @(posedge nvdla_core_clk)
        if (!nvdla_core_rstn) begin
            rd_ptr_q      <= '0;
            rd_ptr_gray_q <= '0;
            pend_q        <= 1'b0;
            cnt_q         <= 2'd0;
            skid0_q       <= '0;
            skid1_q       <= '0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            rd_ptr_gray_q <= PTR_W'(bin2gray(32'(rd_ptr_d)));
            pend_q        <= ram_re;
            cnt_q         <= cnt_d;
            skid0_q       <= skid0_d;
            skid1_q       <= skid1_d;
        end

    assign ram_ra      = rd_ptr_q[DEPTH_LOG2-1:0];
    assign rd_pvld     = cnt_q != 2'd0;
    assign rd_pd       = skid0_q;
    assign rd_ptr_gray = rd_ptr_gray_q;
endmodule
